// File: rtl/mips_defs_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encodings, reset PC default and
// the instruction field positions used by the fetch unit and control decoders.
package mips_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        HOLD    = 2'b10,
        DISCARD = 2'b11
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Fetch PC register: synchronous reset to RESET_PC, +4 increment and
// word-aligned redirect load (load has priority over increment).
module fetch_pc_reg #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            fetch_pc <= RESET_PC & ALIGN_MASK;
        end else if (load) begin
            fetch_pc <= target & ALIGN_MASK;
        end else if (inc) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, runs the req/ready handshake to
// instruction memory and presents one instruction at a time with valid/stall.
module instr_fetch
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rstN,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemReady,
    input  logic [31:0]       imemRdata,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              stall,
    output logic              instrValid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pcPlus4,
    output logic [5:0]        opcode,
    output logic [5:0]        funct
);

    fetch_state_t      state, next_state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] saved_target;
    logic [ADDR_W-1:0] load_target;
    logic              pc_inc;
    logic              pc_load;
    logic              capture;
    logic              clear_valid;
    logic              save_target;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_fetch_pc_reg (
        .clk      (clk),
        .rstN     (rstN),
        .inc      (pc_inc),
        .load     (pc_load),
        .target   (load_target),
        .fetch_pc (fetch_pc)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        load_target = saved_target;
        capture     = 1'b0;
        clear_valid = 1'b0;
        save_target = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                if (imemReady && branchTaken) begin
                    pc_load     = 1'b1;
                    load_target = branchTarget;
                end else if (imemReady) begin
                    capture    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = HOLD;
                end else if (branchTaken) begin
                    save_target = 1'b1;
                    next_state  = DISCARD;
                end
            end
            // Outstanding request must complete before redirecting; the
            // returned word is dropped and the latest target wins.
            DISCARD: begin
                if (imemReady) begin
                    pc_load     = 1'b1;
                    load_target = branchTaken ? branchTarget : saved_target;
                    next_state  = FETCH;
                end else if (branchTaken) begin
                    save_target = 1'b1;
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    clear_valid = 1'b1;
                    pc_load     = 1'b1;
                    load_target = branchTarget;
                    next_state  = FETCH;
                end else if (!stall) begin
                    clear_valid = 1'b1;
                    next_state  = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            instrValid   <= 1'b0;
            instr        <= '0;
            pc           <= '0;
            saved_target <= '0;
        end else begin
            if (capture) begin
                instrValid <= 1'b1;
                instr      <= imemRdata;
                pc         <= fetch_pc;
            end else if (clear_valid) begin
                instrValid <= 1'b0;
            end
            if (save_target) begin
                saved_target <= branchTarget;
            end
        end
    end

    // Gated by rstN so a request in flight is withdrawn as soon as reset is seen.
    assign imemReq  = rstN && ((state == FETCH) || (state == DISCARD));
    assign imemAddr = fetch_pc;
    assign pcPlus4  = pc + ADDR_W'(4);
    assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct    = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven cycle vectors with a
// scoreboard of fetched instructions, plus a hand-written PC wrap sequence.
module tb_instr_fetch;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          br;
        logic [31:0] tgt;
        bit          stl;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        bit          e_zero;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    int          tests = 0;
    int          fails = 0;

    logic        rstN, imemReq, imemReady, branchTaken, stall, instrValid;
    logic [31:0] imemAddr, imemRdata, branchTarget, instr, pc, pcPlus4;
    logic [5:0]  opcode, funct;

    logic        rstN2, imemReq2, imemReady2, branchTaken2, stall2, instrValid2;
    logic [31:0] imemAddr2, imemRdata2, branchTarget2, instr2, pc2, pcPlus42;
    logic [5:0]  opcode2, funct2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem = 32'h8C08_0004;
            32'h0000_0008: mem = 32'h0085_1020;
            default:       mem = {16'hC0DE, a[15:0]} ^ 32'h0000_5A00;
        endcase
    endfunction

    assign imemRdata  = mem(imemAddr);
    assign imemRdata2 = mem(imemAddr2);

    instr_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk(clk), .rstN(rstN), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemRdata(imemRdata), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .stall(stall), .instrValid(instrValid),
        .instr(instr), .pc(pc), .pcPlus4(pcPlus4), .opcode(opcode), .funct(funct)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(32)) dut_wrap (
        .clk(clk), .rstN(rstN2), .imemReq(imemReq2), .imemAddr(imemAddr2),
        .imemReady(imemReady2), .imemRdata(imemRdata2), .branchTaken(branchTaken2),
        .branchTarget(branchTarget2), .stall(stall2), .instrValid(instrValid2),
        .instr(instr2), .pc(pc2), .pcPlus4(pcPlus42), .opcode(opcode2), .funct(funct2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t r(input bit rst, input bit rdy, input bit br, input logic [31:0] tgt,
                               input bit stl, input bit e_req, input logic [31:0] e_addr,
                               input bit e_valid, input bit e_zero);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt; v.stl = stl;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_zero = e_zero;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[$];
    exp_t sbq[$];
    exp_t last;
    bit   pending;

    initial begin
        // Main DUT: rows are (outputs checked at negedge) then (inputs for next edge).
        //             rst rdy br tgt            stl req addr           vld zero
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  0, 32'h0,         0,  1));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h0,         0,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  0, 32'h0,         1,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  1, 32'h4,         0,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  1, 32'h4,         0,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  1, 32'h4,         0,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h4,         0,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  0, 32'h0,         1,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h8,         0,  0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(r(1, 1, 0, 32'h0,    1,  0, 32'h0,         1,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  0, 32'h0,         1,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'hC,         0,  0));
        vecs.push_back(r(1, 0, 1, 32'h103,      1,  0, 32'h0,         1,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h100,       0,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  0, 32'h0,         1,  0));
        vecs.push_back(r(1, 0, 1, 32'h103,      0,  1, 32'h104,       0,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  1, 32'h104,       0,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h104,       0,  0));
        vecs.push_back(r(1, 0, 1, 32'h1F0,      0,  1, 32'h100,       0,  0));
        vecs.push_back(r(1, 0, 1, 32'h200,      0,  1, 32'h100,       0,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h100,       0,  0));
        vecs.push_back(r(1, 1, 1, 32'h30A,      0,  1, 32'h200,       0,  0));
        vecs.push_back(r(1, 0, 1, 32'h400,      0,  1, 32'h308,       0,  0));
        vecs.push_back(r(1, 1, 1, 32'h500,      0,  1, 32'h308,       0,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  1, 32'h500,       0,  0));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  0, 32'h0,         1,  0));
        vecs.push_back(r(0, 1, 0, 32'h0,        0,  1, 32'h504,       0,  0));
        vecs.push_back(r(0, 1, 0, 32'h0,        0,  0, 32'h0,         0,  1));
        vecs.push_back(r(1, 1, 0, 32'h0,        0,  0, 32'h0,         0,  1));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  1, 32'h0,         0,  0));
        vecs.push_back(r(1, 0, 0, 32'h0,        0,  1, 32'h0,         0,  0));

        rstN = 1'b0; imemReady = 1'b1; branchTaken = 1'b0; branchTarget = '0; stall = 1'b0;
        rstN2 = 1'b0; imemReady2 = 1'b0; branchTaken2 = 1'b0; branchTarget2 = '0; stall2 = 1'b0;
        pending = 1'b0;
        last = '{32'h0, 32'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            chk($sformatf("row%0d imemReq", i), {31'b0, imemReq}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("row%0d imemAddr", i), imemAddr, vecs[i].e_addr);
            chk($sformatf("row%0d instrValid", i), {31'b0, instrValid}, {31'b0, vecs[i].e_valid});
            if (pending) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("row%0d scoreboard empty", i), 32'h1, 32'h0);
                end else begin
                    last = sbq.pop_front();
                end
                pending = 1'b0;
            end
            if (vecs[i].e_valid) begin
                chk($sformatf("row%0d pc", i), pc, last.pc);
                chk($sformatf("row%0d instr", i), instr, last.ins);
                chk($sformatf("row%0d pcPlus4", i), pcPlus4, last.pc + 32'd4);
                chk($sformatf("row%0d opcode", i), {26'b0, opcode}, {26'b0, last.ins[31:26]});
                chk($sformatf("row%0d funct", i), {26'b0, funct}, {26'b0, last.ins[5:0]});
            end
            if (vecs[i].e_zero) begin
                chk($sformatf("row%0d reset pc", i), pc, 32'h0);
                chk($sformatf("row%0d reset instr", i), instr, 32'h0);
                chk($sformatf("row%0d reset pcPlus4", i), pcPlus4, 32'h4);
                chk($sformatf("row%0d reset opcode", i), {26'b0, opcode}, 32'h0);
                chk($sformatf("row%0d reset funct", i), {26'b0, funct}, 32'h0);
            end
            rstN         = vecs[i].rst;
            imemReady    = vecs[i].rdy;
            branchTaken  = vecs[i].br;
            branchTarget = vecs[i].tgt;
            stall        = vecs[i].stl;
            if (vecs[i].rst && vecs[i].rdy && vecs[i].e_req && !vecs[i].br) begin
                sbq.push_back('{vecs[i].e_addr, mem(vecs[i].e_addr)});
                pending = 1'b1;
            end
            step();
        end
        chk("scoreboard drained", sbq.size(), 32'h0);

        // Specific decoded fields of the first program words.
        chk("word0 opcode", {26'b0, mem(32'h0) >> 26}, 32'h23);
        chk("word8 funct", {26'b0, mem(32'h8) & 32'h3F}, 32'h20);

        // PC wrap from RESET_PC = 0xFFFF_FFFC.
        chk("wrap reset req", {31'b0, imemReq2}, 32'h0);
        rstN2 = 1'b1;
        step();
        chk("wrap first req", {31'b0, imemReq2}, 32'h1);
        chk("wrap first addr", imemAddr2, 32'hFFFF_FFFC);
        imemReady2 = 1'b1;
        step();
        imemReady2 = 1'b0;
        chk("wrap valid", {31'b0, instrValid2}, 32'h1);
        chk("wrap pc", pc2, 32'hFFFF_FFFC);
        chk("wrap pcPlus4", pcPlus42, 32'h0);
        chk("wrap instr", instr2, mem(32'hFFFF_FFFC));
        chk("wrap hold req", {31'b0, imemReq2}, 32'h0);
        step();
        chk("wrap second req", {31'b0, imemReq2}, 32'h1);
        chk("wrap second addr", imemAddr2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit; the issuing end of the instruction stream that the control decoder and ALU-control decoder consume.
- Owns the fetch PC and runs a req/ready handshake to instruction memory.
- Presents one instruction at a time, with valid/stall flow control, and pre-split opcode/funct fields to the control unit.
- Accepts branch/jump redirects from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetch after reset (bits [1:0] must be 0)
ADDR_W, 32, PC/address width

Ports:
clk  input  1  clock
rstN  input  1  synchronous active-low reset
imemReq  output  1  fetch request to instruction memory
imemAddr  output  ADDR_W  word-aligned fetch address
imemReady  input  1  memory returns data this cycle (valid only while imemReq=1)
imemRdata  input  32  instruction word, sampled when imemReq&imemReady
branchTaken  input  1  redirect request (one-cycle pulse)
branchTarget  input  ADDR_W  redirect address; bits [1:0] ignored and forced to 0
stall  input  1  downstream cannot accept presented instruction
instrValid  output  1  instr/pc outputs hold a valid instruction
instr  output  32  fetched instruction
pc  output  ADDR_W  address of instr
pcPlus4  output  ADDR_W  pc+4, modulo 2^ADDR_W
opcode  output  6  instr[31:26], feeds control decoder
funct  output  6  instr[5:0], feeds ALU-control decoder

Behaviour:
- Reset:
  - Sampled at posedge while rstN=0; state<=IDLE, fetchPc<=RESET_PC.
  - Registered outputs reset to: instrValid=0, instr=0, pc=0.
  - imemReq=0 throughout reset.
  - Reset mid-handshake abandons the request; any later imemReady is ignored.
- States:
  - IDLE: imemReq=0; unconditionally -> FETCH next cycle. First request is issued the 2nd cycle after rstN rises.
  - FETCH: imemReq=1, imemAddr=fetchPc.
    - On ready and no branchTaken: instr<=imemRdata, pc<=fetchPc, instrValid<=1, fetchPc<=fetchPc+4, -> HOLD.
    - On ready and branchTaken in the same cycle: data dropped, fetchPc<=target, stay FETCH.
    - On branchTaken without ready: savedTarget<=target, -> DISCARD.
    - Otherwise: hold.
  - DISCARD: imemReq=1, imemAddr unchanged (old fetchPc).
    - On ready: data dropped, fetchPc<=savedTarget, -> FETCH.
    - Further branchTaken overwrites savedTarget; the latest redirect wins.
    - Redirect and ready in the same cycle: the new target is used directly.
  - HOLD: imemReq=0, instrValid=1.
    - branchTaken has priority over stall: instrValid<=0, fetchPc<=target, -> FETCH.
    - Else if stall=0: instruction consumed this cycle; instrValid<=0, -> FETCH.
    - Else hold all outputs stable.
- Handshake rules:
  - imemAddr must not change while imemReq=1 and imemReady=0.
  - imemReq never drops before ready once raised (outside reset).
  - imemReady while imemReq=0 is ignored.
- Latency: minimum 2 cycles per instruction (FETCH with same-cycle ready, then HOLD); throughput 1 instr / 2 cycles without stalls.
- Arithmetic: PC increment wraps 32'hFFFF_FFFC+4 -> 0. pcPlus4 is combinational from pc.
- opcode/funct are combinational slices of instr and equal 0 after reset.

Decomposition:
- Shared package (mips_defs):
  - fetch state encodings IDLE/FETCH/HOLD/DISCARD (2-bit)
  - RESET_PC default
  - OPCODE_MSB/LSB (31/26) and FUNCT_MSB/LSB (5/0) field constants, shared with the control decoders.
- One sub-module: fetch_pc_reg (fetchPc register with reset, +4 increment, aligned redirect load).

Test Plan:
- Reset release, memory ready every cycle:
  - imemReq=0 during reset and the first cycle after release.
  - Then addresses 0x0, 0x4, 0x8 on alternating cycles.
  - instr=0x8C080004 presented with opcode=6'h23, pc=0x0, pcPlus4=0x4.
- Memory ready delayed 3 cycles at addr 0x4: imemAddr held at 0x4 and imemReq high for all 4 cycles; instrValid rises the cycle after ready.
- stall=1 for 5 cycles while HOLDing instr 0x00851020 at pc=0x8:
  - outputs stable; funct=6'h20; no imemReq.
  - After stall drops, the next fetch goes to 0xC.
- branchTaken, target 0x103 (→0x100):
  - asserted in HOLD: instrValid=0 next cycle, next fetch at 0x100.
  - asserted in FETCH with ready 2 cycles later: old data dropped, no valid pulse, next fetch at 0x100.
  - a second redirect to 0x200 during DISCARD wins.
- RESET_PC=32'hFFFF_FFFC: the second fetch address is 0x0 (wrap).
- rstN low mid-request while imemReady is pulsed: instrValid stays 0; the next fetch after release is at RESET_PC.
